// File: rtl/sink_list_writer_pkg.sv
// rtl/sink_list_writer_pkg.sv - shared constants and state encoding for the sink-list writer and reader
package sink_list_writer_pkg;

  // Memory word, address and node ID width
  localparam int unsigned WORD_WIDTH  = 16;
  // Memory size in bytes (8-bit cells)
  localparam int unsigned MEM_DEPTH   = 1024;
  // Largest list that fits after the header word
  localparam int unsigned MAX_ENTRIES = 511;
  // Header word (entry count) location
  localparam int unsigned HEADER_ADDR = 0;
  // Bytes occupied by one list word
  localparam int unsigned ENTRY_BYTES = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_HEADER  = 2'd2,
    ST_FINISH  = 2'd3
  } state_t;

  // Byte address of list entry idx; entries start right after the header word
  function automatic int unsigned entry_addr(input int unsigned idx);
    return HEADER_ADDR + ENTRY_BYTES * (idx + 1);
  endfunction

endpackage

// File: rtl/sink_list_writer_if.sv
// rtl/sink_list_writer_if.sv - beat stream, control and memory-write bundle of the sink-list writer
interface sink_list_writer_if #(
  parameter int unsigned WORD_WIDTH = sink_list_writer_pkg::WORD_WIDTH
);

  logic                  start;
  logic                  in_valid;
  logic [WORD_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  list_end;
  logic [WORD_WIDTH-1:0] address;
  logic                  wr_en;
  logic [WORD_WIDTH-1:0] mem_data_in;
  logic                  busy;
  logic                  done;
  logic                  overflow;

  // Producer of node IDs and consumer of the memory writes
  modport master (
    output start, in_valid, in_data, list_end,
    input  in_ready, address, wr_en, mem_data_in, busy, done, overflow
  );

  // The writer itself
  modport slave (
    input  start, in_valid, in_data, list_end,
    output in_ready, address, wr_en, mem_data_in, busy, done, overflow
  );

endinterface

// File: rtl/sink_list_writer.sv
// rtl/sink_list_writer.sv - writes a counted list of sink node IDs into byte-addressed memory
module sink_list_writer #(
  parameter int unsigned WORD_WIDTH  = sink_list_writer_pkg::WORD_WIDTH,
  parameter int unsigned MEM_DEPTH   = sink_list_writer_pkg::MEM_DEPTH,
  parameter int unsigned MAX_ENTRIES = sink_list_writer_pkg::MAX_ENTRIES
) (
  input  logic               clock,
  input  logic               reset,
  sink_list_writer_if.slave  bus
);

  import sink_list_writer_pkg::*;

  // Entries are also bounded by the memory so the top address stays at MEM_DEPTH-2
  localparam int unsigned MEM_ENTRIES = MEM_DEPTH / ENTRY_BYTES - 1;
  localparam int unsigned CAP_ENTRIES = (MAX_ENTRIES < MEM_ENTRIES) ? MAX_ENTRIES : MEM_ENTRIES;
  localparam logic [WORD_WIDTH-1:0] CAP_W  = WORD_WIDTH'(CAP_ENTRIES);
  localparam logic [WORD_WIDTH-1:0] HDR_W  = WORD_WIDTH'(HEADER_ADDR);

  state_t                state;
  logic [WORD_WIDTH-1:0] count;
  logic [WORD_WIDTH-1:0] address_q;
  logic [WORD_WIDTH-1:0] mem_data_q;
  logic                  wr_en_q;
  logic                  in_ready_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  overflow_q;

  assign bus.address     = address_q;
  assign bus.mem_data_in = mem_data_q;
  assign bus.wr_en       = wr_en_q;
  assign bus.in_ready    = in_ready_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.overflow    = overflow_q;

  // List-writing FSM with inline entry counter; every output is registered
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      count      <= '0;
      address_q  <= '0;
      mem_data_q <= '0;
      wr_en_q    <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          wr_en_q <= 1'b0;
          done_q  <= 1'b0;
          if (bus.start) begin
            state      <= ST_COLLECT;
            count      <= '0;
            overflow_q <= 1'b0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end

        ST_COLLECT: begin
          wr_en_q <= 1'b0;
          // A beat arriving with list_end is still written; the header follows next cycle
          if (bus.in_valid && in_ready_q) begin
            if (count < CAP_W) begin
              wr_en_q    <= 1'b1;
              address_q  <= WORD_WIDTH'(entry_addr(32'(count)));
              mem_data_q <= bus.in_data;
              count      <= count + 1'b1;
            end else begin
              overflow_q <= 1'b1;
            end
          end
          if (bus.list_end) begin
            state      <= ST_HEADER;
            in_ready_q <= 1'b0;
          end
        end

        ST_HEADER: begin
          // Header goes last so a reader never sees a count covering unwritten entries
          wr_en_q    <= 1'b1;
          address_q  <= HDR_W;
          mem_data_q <= count;
          state      <= ST_FINISH;
        end

        ST_FINISH: begin
          wr_en_q <= 1'b0;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state   <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
